pc_cfr_cpg_alloc: RTL and testbench
===================================

Name: pc_cfr_cpg_alloc

Overview:
Scheduler between the peak-cancellation CFR peak detector and a pool of NUM_CPG cancellation pulse generators (CPGs).
- Takes qualified peaks (excess magnitude, angle, phase, valid) and assigns each to an idle CPG slot.
- Tracks per-slot busy time for the pulse length.
- Drops peaks when the pool is exhausted and keeps allocation/drop statistics for software.

Parameters:
NUM_CPG, 4, number of CPG slots managed (2..16)
PULSE_LEN, 64, clock cycles a CPG stays busy after start (>=2)
DATA_WIDTH, 16, peak magnitude is DATA_WIDTH+1 bits
ITERATIONS, 7, peak angle is ITERATIONS+1 bits
CNT_WIDTH, 16, width of statistic counters

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
peak_r  in  DATA_WIDTH+1  peak excess magnitude (unsigned)
peak_theta  in  ITERATIONS+1  peak angle
peak_phase  in  1  peak sample phase (0 = p0, 1 = p1)
peak_valid  in  1  peak qualifier, single-cycle, may assert every cycle
cpg_start  out  NUM_CPG  one-hot start pulse to selected slot
cpg_r  out  DATA_WIDTH+1  magnitude for started slot
cpg_theta  out  ITERATIONS+1  angle for started slot
cpg_phase  out  1  phase for started slot
cpg_busy  out  NUM_CPG  per-slot busy flag
stat_alloc_cnt  out  CNT_WIDTH  peaks allocated, saturating
stat_drop_cnt  out  CNT_WIDTH  peaks dropped (pool full), saturating
ctrl_enable  in  1  allow new allocations
ctrl_clear_stats  in  1  synchronous clear of both statistic counters

Behaviour:
- Reset (rst_n low at a clk edge): all slot counters 0, cpg_start/cpg_busy 0, cpg_r/cpg_theta/cpg_phase 0, both stats 0, RR pointer 0.
  - Reset mid-operation aborts all slots; cpg_busy is 0 in the first cycle after the reset edge.
- Per-slot down-counter cnt_i (width clog2(PULSE_LEN+1)). cpg_busy[i] = (cnt_i != 0), decoded directly from registers.
- Request: req = peak_valid && ctrl_enable && (peak_r != 0).
  - peak_valid with peak_r == 0, or with ctrl_enable low, is ignored: no start, no drop count.
- Selection is combinational on current cpg_busy. Default policy: lowest-index idle slot.
- Allocation, when req and an idle slot exists (1-cycle latency). On the edge:
  - cpg_start <= onehot(sel).
  - cpg_r/theta/phase <= peak inputs.
  - cnt_sel <= PULSE_LEN.
  - stat_alloc_cnt += 1.
- Slot timing: busy for exactly PULSE_LEN cycles, starting the cycle cpg_start is high. Every other nonzero counter decrements each cycle.
- Non-start cycles: cpg_start = 0 and cpg_r/theta/phase are driven to 0.
- Drop: req with all slots busy increments stat_drop_cnt; outputs unchanged.
  - A slot with cnt = 1 still counts as busy in that cycle; it is free the following cycle.
- ctrl_enable low: running slots count down to completion. Deasserting it mid-pulse does not truncate pulses.
- Statistics: saturate at 2^CNT_WIDTH-1. ctrl_clear_stats has priority over a same-cycle increment, giving 0.
- At most one allocation per cycle.

Optional Feature:
PC_CFR_CPG_ALLOC_RR_EN
- Defined: round-robin selection. Search starts at slot (last_alloc+1) mod NUM_CPG and takes the first idle slot. The pointer is updated only on allocation.
- Undefined: fixed lowest-index priority; no pointer register.
- Timing, statistics and drop rules are identical in both builds.

Test Plan:
All scenarios use NUM_CPG=4, PULSE_LEN=8.
1. Reset: rst_n low 3 cycles while peak_valid toggles -> all outputs 0 throughout and on the first cycle after release.
2. Single peak: r=100, theta=5, phase=1 at cycle t -> cpg_start=4'b0001, cpg_r=100, cpg_theta=5, cpg_phase=1 at t+1. cpg_busy[0] high t+1..t+8, low at t+9. stat_alloc_cnt=1.
3. Pool exhaustion: peaks in 5 consecutive cycles -> starts 0001, 0010, 0100, 1000; 5th dropped; alloc=4, drop=1.
   - RR build: a 6th peak after slot 0 frees goes to slot 0; a 7th after slots 0 and 1 free goes to slot 1.
4. Boundary: all busy, peak in slot 0's last busy cycle -> dropped. Peak the next cycle -> cpg_start=0001.
5. Gating: ctrl_enable=0 with 3 peaks, plus one peak_valid with r=0 -> no cpg_start, stats unchanged. An in-flight slot still completes its 8 busy cycles.
6. Saturation/clear: CNT_WIDTH=4, 20 drops -> stat_drop_cnt=15. ctrl_clear_stats concurrent with a drop -> 0 next cycle.

Source files
------------

// File: rtl/pc_cfr_cpg_alloc.sv
// Peak-to-CPG scheduler: hands qualified CFR peaks to idle pulse generators, times each pulse, keeps stats.
// Optional macro PC_CFR_CPG_ALLOC_RR_EN selects round-robin slot search instead of lowest-index priority.
`timescale 1ns/1ps
module pc_cfr_cpg_alloc #(
  parameter int NUM_CPG    = 4,
  parameter int PULSE_LEN  = 64,
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   peak_r,
  input  logic [ITERATIONS:0]   peak_theta,
  input  logic                  peak_phase,
  input  logic                  peak_valid,
  output logic [NUM_CPG-1:0]    cpg_start,
  output logic [DATA_WIDTH:0]   cpg_r,
  output logic [ITERATIONS:0]   cpg_theta,
  output logic                  cpg_phase,
  output logic [NUM_CPG-1:0]    cpg_busy,
  output logic [CNT_WIDTH-1:0]  stat_alloc_cnt,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
  input  logic                  ctrl_enable,
  input  logic                  ctrl_clear_stats
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam int IW = $clog2(NUM_CPG);

  logic [CW-1:0]        cnt_q [NUM_CPG];
  logic [NUM_CPG-1:0]   busy;
  logic                 req;
  logic                 found;
  logic [IW-1:0]        sel;
  logic                 alloc;
  logic                 drop;
  logic [NUM_CPG-1:0]   start_d;

  always_comb begin
    for (int i = 0; i < NUM_CPG; i++) busy[i] = (cnt_q[i] != '0);
  end
  assign cpg_busy = busy;

  assign req   = peak_valid && ctrl_enable && (peak_r != '0);
  assign alloc = req && found;
  assign drop  = req && !found;

`ifdef PC_CFR_CPG_ALLOC_RR_EN
  // ptr_q holds the slot where the next search begins (last allocated slot + 1).
  logic [IW-1:0] ptr_q;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_CPG; k++) begin
      automatic int j = int'(ptr_q) + k;
      if (j >= NUM_CPG) j = j - NUM_CPG;
      if (!found && !busy[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (alloc) begin
      ptr_q <= (int'(sel) == NUM_CPG - 1) ? '0 : sel + IW'(1);
    end
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_CPG - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end
`endif

  always_comb begin
    start_d = '0;
    if (alloc) start_d[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CPG; i++) cnt_q[i] <= '0;
      cpg_start      <= '0;
      cpg_r          <= '0;
      cpg_theta      <= '0;
      cpg_phase      <= 1'b0;
      stat_alloc_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      // A freshly started slot loads the full length; the cycle cpg_start is high is its first busy cycle.
      for (int i = 0; i < NUM_CPG; i++) begin
        if (alloc && (sel == IW'(i)))
          cnt_q[i] <= CW'(PULSE_LEN);
        else if (cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - CW'(1);
      end
      cpg_start <= start_d;
      cpg_r     <= alloc ? peak_r     : '0;
      cpg_theta <= alloc ? peak_theta : '0;
      cpg_phase <= alloc ? peak_phase : 1'b0;

      if (ctrl_clear_stats)
        stat_alloc_cnt <= '0;
      else if (alloc && (stat_alloc_cnt != '1))
        stat_alloc_cnt <= stat_alloc_cnt + CNT_WIDTH'(1);

      if (ctrl_clear_stats)
        stat_drop_cnt <= '0;
      else if (drop && (stat_drop_cnt != '1))
        stat_drop_cnt <= stat_drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_cfr_cpg_alloc.sv
// Bench for pc_cfr_cpg_alloc: directed scenarios plus random traffic against a slot-deadline reference model.
`timescale 1ns/1ps
module tb_pc_cfr_cpg_alloc;

  localparam int NUM_CPG    = 4;
  localparam int PULSE_LEN  = 8;
  localparam int DATA_WIDTH = 16;
  localparam int ITERATIONS = 7;
  localparam int CNT_WIDTH  = 4;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  logic                 clk;
  logic                 rst_n;
  logic [DATA_WIDTH:0]  peak_r;
  logic [ITERATIONS:0]  peak_theta;
  logic                 peak_phase;
  logic                 peak_valid;
  logic [NUM_CPG-1:0]   cpg_start;
  logic [DATA_WIDTH:0]  cpg_r;
  logic [ITERATIONS:0]  cpg_theta;
  logic                 cpg_phase;
  logic [NUM_CPG-1:0]   cpg_busy;
  logic [CNT_WIDTH-1:0] stat_alloc_cnt;
  logic [CNT_WIDTH-1:0] stat_drop_cnt;
  logic                 ctrl_enable;
  logic                 ctrl_clear_stats;

  pc_cfr_cpg_alloc #(
    .NUM_CPG(NUM_CPG), .PULSE_LEN(PULSE_LEN), .DATA_WIDTH(DATA_WIDTH),
    .ITERATIONS(ITERATIONS), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .peak_r(peak_r), .peak_theta(peak_theta), .peak_phase(peak_phase), .peak_valid(peak_valid),
    .cpg_start(cpg_start), .cpg_r(cpg_r), .cpg_theta(cpg_theta), .cpg_phase(cpg_phase),
    .cpg_busy(cpg_busy), .stat_alloc_cnt(stat_alloc_cnt), .stat_drop_cnt(stat_drop_cnt),
    .ctrl_enable(ctrl_enable), .ctrl_clear_stats(ctrl_clear_stats)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: each slot is free from the cycle number stored in free_at onward
  int cyc;
  int free_at [NUM_CPG];
  int next_slot;
  int exp_alloc, exp_drop;
  logic [NUM_CPG-1:0]  exp_start;
  logic [DATA_WIDTH:0] exp_r;
  logic [ITERATIONS:0] exp_theta;
  logic                exp_phase;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick_slot();
    int first;
    first = -1;
`ifdef PC_CFR_CPG_ALLOC_RR_EN
    for (int k = 0; k < NUM_CPG; k++) begin
      int j;
      j = (next_slot + k) % NUM_CPG;
      if (first < 0 && free_at[j] <= cyc) first = j;
    end
`else
    for (int i = 0; i < NUM_CPG; i++)
      if (first < 0 && free_at[i] <= cyc) first = i;
`endif
    return first;
  endfunction

  // one clock: drive inputs, advance the model, compare after the edge
  task automatic step(input logic v, input logic [DATA_WIDTH:0] r, input logic [ITERATIONS:0] th,
                      input logic ph, input logic en, input logic clr, input logic rn);
    int s;
    logic [NUM_CPG-1:0] exp_busy;
    peak_valid = v; peak_r = r; peak_theta = th; peak_phase = ph;
    ctrl_enable = en; ctrl_clear_stats = clr; rst_n = rn;
    exp_start = '0; exp_r = '0; exp_theta = '0; exp_phase = 1'b0;
    if (!rn) begin
      for (int i = 0; i < NUM_CPG; i++) free_at[i] = 0;
      next_slot = 0; exp_alloc = 0; exp_drop = 0;
    end else begin
      if (v && en && r != 0) begin
        s = pick_slot();
        if (s >= 0) begin
          free_at[s] = cyc + 1 + PULSE_LEN;
          next_slot = (s + 1) % NUM_CPG;
          exp_start = NUM_CPG'(1 << s);
          exp_r = r; exp_theta = th; exp_phase = ph;
          if (exp_alloc < CNT_MAX) exp_alloc++;
        end else if (exp_drop < CNT_MAX) exp_drop++;
      end
      if (clr) begin
        exp_alloc = 0; exp_drop = 0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM_CPG; i++) exp_busy[i] = (free_at[i] > cyc);
    check("cpg_start", 32'(cpg_start), 32'(exp_start));
    check("cpg_r",     32'(cpg_r),     32'(exp_r));
    check("cpg_theta", 32'(cpg_theta), 32'(exp_theta));
    check("cpg_phase", 32'(cpg_phase), 32'(exp_phase));
    check("cpg_busy",  32'(cpg_busy),  32'(exp_busy));
    check("alloc_cnt", 32'(stat_alloc_cnt), 32'(exp_alloc));
    check("drop_cnt",  32'(stat_drop_cnt),  32'(exp_drop));
    @(negedge clk);
  endtask

  task automatic peak(input logic [DATA_WIDTH:0] r);
    step(1'b1, r, ITERATIONS'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; next_slot = 0;
    exp_alloc = 0; exp_drop = 0;
    for (int i = 0; i < NUM_CPG; i++) free_at[i] = 0;
    rst_n = 1'b0; peak_valid = 1'b0; peak_r = '0; peak_theta = '0; peak_phase = 1'b0;
    ctrl_enable = 1'b1; ctrl_clear_stats = 1'b0;

    // reset held while peaks toggle
    for (int i = 0; i < 3; i++) step(1'(i), 17'd50, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // single peak, then let it expire
    step(1'b1, 17'd100, 8'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(PULSE_LEN + 1);

    // pool exhaustion, then refills as slots free
    for (int i = 0; i < 5; i++) peak(17'(i + 1));
    idle(3);
    peak(17'd7);
    peak(17'd8);
    idle(PULSE_LEN + 2);

    // boundary: refill pool, peak in slot 0's final busy cycle, then one cycle later
    for (int i = 0; i < 4; i++) peak(17'(i + 9));
    idle(PULSE_LEN - 4);
    peak(17'd20);
    peak(17'd21);
    idle(PULSE_LEN + 1);

    // gating: disabled peaks and zero-magnitude peak are ignored; in-flight pulse completes
    peak(17'd30);
    for (int i = 0; i < 3; i++) step(1'b1, 17'd31, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 17'd0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < PULSE_LEN; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // saturation, then clear concurrent with a drop
    for (int i = 0; i < 60; i++) peak(17'(i + 40));
    check("drop_sat", 32'(stat_drop_cnt), CNT_MAX);
    check("alloc_sat", 32'(stat_alloc_cnt), CNT_MAX);
    for (int i = 0; i < 4; i++) peak(17'd99);
    step(1'b1, 17'd5, 8'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_drop", 32'(stat_drop_cnt), 0);
    idle(PULSE_LEN + 1);

    // random traffic with occasional reset, clear and disable
    for (int n = 0; n < 3000; n++) begin
      logic v, en, clr, rn;
      logic [DATA_WIDTH:0] r;
      v   = ($urandom_range(0, 99) < 60);
      r   = ($urandom_range(0, 7) == 0) ? '0 : 17'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 49) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      step(v, r, 8'($urandom), 1'($urandom), en, clr, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
